// File: rtl/wb_arb_2to1.sv
// wb_arb_2to1: two-master / one-slave Wishbone classic arbiter.
// m0 is the instruction-fetch master and m1 is the data master. They share one slave bus.
// The grant is registered, and masters take turns (round-robin) when they request together.
// The owning master keeps the bus until it drops cyc.
// A bus-timeout counter stops a hung slave from locking up the granted master.
module wb_arb_2to1 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // master 0 (instruction fetch)
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1 (data)
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // shared slave bus
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i
);

  localparam int CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q,  last_d;   // master that owned the bus most recently
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          gnt0, gnt1;
  logic          to_hit;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Next grant. Every hand-over goes through IDLE, so ownership never passes directly between masters.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request mux. The slave sees only the owner's signals; in IDLE the slave bus is quiet.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_stb_o = m0_stb_i;
      s_cyc_o = m0_cyc_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_stb_o = m1_stb_i;
      s_cyc_o = m1_cyc_i;
    end
  end

  // The timeout fires on the last waiting cycle. An ack in that same cycle wins, because to_hit needs !s_ack_i.
  assign to_hit = (TIMEOUT != 0) && s_stb_o && !s_ack_i && (cnt_q == TO_LAST);

  // Wait counter: counts strobe cycles that get no ack; cleared by an ack, by IDLE or by an error.
  always_comb begin
    cnt_d = cnt_q;
    if (TIMEOUT == 0)                          cnt_d = '0;
    else if (state_q == IDLE || s_ack_i || to_hit) cnt_d = '0;
    else if (s_stb_o)                          cnt_d = cnt_q + CW'(1);
  end

  // Response routing. Only the owner sees ack, err or read data; an ack arriving in IDLE goes nowhere.
  always_comb begin
    m0_ack_o = s_ack_i & gnt0;
    m1_ack_o = s_ack_i & gnt1;
    m0_err_o = to_hit & gnt0;
    m1_err_o = to_hit & gnt1;
    m0_dat_o = gnt0 ? s_dat_i : '0;
    m1_dat_o = gnt1 ? s_dat_i : '0;
  end

  // Grant, round-robin pointer and timeout counter. Reset abandons any transfer in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arb_2to1.sv
// Directed bench for wb_arb_2to1. The DUT is built with TIMEOUT=4.
// Each expected value below is worked out by hand.
module tb_wb_arb_2to1;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   m0_adr, m1_adr, s_adr;
  logic [DW-1:0]   m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
  logic            m0_we, m1_we, s_we;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic            m0_stb, m1_stb, s_stb, m0_cyc, m1_cyc, s_cyc;
  logic            m0_ack, m1_ack, m0_err, m1_err, s_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arb_2to1 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk),     .wb_rst_i(rst),
    .m0_adr_i(m0_adr),  .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel),  .m0_stb_i(m0_stb),   .m0_cyc_i(m0_cyc),   .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_adr_i(m1_adr),  .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel),  .m1_stb_i(m1_stb),   .m1_cyc_i(m1_cyc),   .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_adr_o(s_adr),    .s_dat_o(s_dat_w),   .s_we_o(s_we),       .s_sel_o(s_sel),
    .s_stb_o(s_stb),    .s_cyc_o(s_cyc),     .s_dat_i(s_dat_r),   .s_ack_i(s_ack)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // step past the next rising edge; outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic on, input logic [AW-1:0] adr);
    m0_cyc = on; m0_stb = on; m0_adr = adr;
  endtask

  task automatic m1_req(input logic on, input logic [AW-1:0] adr);
    m1_cyc = on; m1_stb = on; m1_adr = adr;
  endtask

  initial begin
    rst = 1'b1;
    m0_adr = '0; m0_dat_w = '0; m0_we = 1'b0; m0_sel = 4'hF; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat_w = '0; m1_we = 1'b0; m1_sel = 4'hF; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat_r = 32'h55; s_ack = 1'b0;

    // reset state
    #3;
    chk("rst_s_cyc",  s_cyc, 0);
    chk("rst_s_stb",  s_stb, 0);
    chk("rst_m0_dat", m0_dat_r, 0);
    chk("rst_m0_ack", m0_ack, 0);
    #9 rst = 1'b0;
    s_dat_r = '0;

    // tie straight after reset goes to m0, then one IDLE cycle, then m1, then m0 again
    m0_req(1, 32'h10); m1_req(1, 32'h20);
    #1 chk("tie_lat_idle", s_cyc, 0);
    tick();
    chk("tie_first_m0", s_adr, 32'h10);
    s_ack = 1'b1; #1;
    chk("tie_m0_ack", m0_ack, 1);
    chk("tie_m1_noack", m1_ack, 0);
    tick(); s_ack = 1'b0; m0_req(0, 0);
    tick();
    chk("tie_idle_gap", s_cyc, 0);
    tick();
    chk("tie_then_m1", s_adr, 32'h20);
    s_ack = 1'b1; #1;
    chk("tie_m1_ack", m1_ack, 1);
    chk("tie_m0_noack", m0_ack, 0);
    m0_req(1, 32'h30);
    tick(); s_ack = 1'b0; m1_req(0, 0);
    tick(); m1_req(1, 32'h40);
    tick();
    chk("alt_back_m0", s_adr, 32'h30);
    m0_req(0, 0); m1_req(0, 0);
    tick();

    // m0 alone, slave acks after two wait cycles
    m0_req(1, 32'h100);
    #1 chk("m0_lat_idle", s_cyc, 0);
    tick();
    chk("m0_s_cyc", s_cyc, 1);
    chk("m0_s_stb", s_stb, 1);
    chk("m0_s_adr", s_adr, 32'h100);
    chk("m0_wait1", m0_ack, 0);
    tick();
    chk("m0_wait2", m0_ack, 0);
    tick(); s_ack = 1'b1; s_dat_r = 32'hCAFE0001; #1;
    chk("m0_ack", m0_ack, 1);
    chk("m0_rdata", m0_dat_r, 32'hCAFE0001);
    chk("m1_rdata_blk", m1_dat_r, 0);
    tick(); s_ack = 1'b0; s_dat_r = '0; m0_req(0, 0);
    tick();

    // m1 write held off while m0 owns the bus
    m0_req(1, 32'h500);
    tick();
    m1_req(1, 32'h2000); m1_we = 1'b1; m1_dat_w = 32'hDEADBEEF; m1_sel = 4'b0011; #1;
    chk("hold_adr_m0", s_adr, 32'h500);
    chk("hold_we_m0", s_we, 0);
    s_ack = 1'b1; #1;
    chk("hold_m1_noack", m1_ack, 0);
    tick(); s_ack = 1'b0; m0_req(0, 0);
    tick();
    chk("hold_idle", s_cyc, 0);
    tick();
    chk("wr_adr", s_adr, 32'h2000);
    chk("wr_dat", s_dat_w, 32'hDEADBEEF);
    chk("wr_sel", s_sel, 4'b0011);
    chk("wr_we", s_we, 1);
    s_ack = 1'b1; #1;
    chk("wr_ack", m1_ack, 1);
    tick(); s_ack = 1'b0; m1_req(0, 0); m1_we = 1'b0;
    tick();

    // timeout: slave never acks, err only in the 4th strobe cycle
    m0_req(1, 32'h600);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("to_err_c%0d", i), m0_err, (i == 4) ? 64'd1 : 64'd0);
      chk($sformatf("to_ack_c%0d", i), m0_ack, 0);
    end
    m0_req(0, 0);
    tick();

    // ack arriving in the TIMEOUT-1 cycle wins over the error
    m1_req(1, 32'h640);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("race_err_c%0d", i), m1_err, 0);
    end
    tick(); s_ack = 1'b1; #1;
    chk("race_ack", m1_ack, 1);
    chk("race_no_err", m1_err, 0);
    tick(); s_ack = 1'b0; m1_req(0, 0);
    tick();

    // ack from the slave while IDLE goes to nobody
    s_ack = 1'b1; #1;
    chk("idle_ack_m0", m0_ack, 0);
    chk("idle_ack_m1", m1_ack, 0);
    s_ack = 1'b0;

    // leave last grant at m0, then reset while m1 owns the bus
    m0_req(1, 32'h700);
    tick(); m0_req(0, 0);
    tick(); m1_req(1, 32'h780);
    tick();
    chk("pre_rst_gnt1", s_adr, 32'h780);
    s_dat_r = 32'h1234; s_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cyc", s_cyc, 0);
    chk("rst_mid_adr", s_adr, 0);
    chk("rst_mid_ack", m1_ack, 0);
    chk("rst_mid_dat", m1_dat_r, 0);
    s_ack = 1'b0; s_dat_r = '0;
    tick();
    rst = 1'b0;
    m0_req(1, 32'h800);
    tick();
    chk("rst_tie_m0", s_adr, 32'h800);
    m0_req(0, 0); m1_req(0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
